// File: rtl/dec38_rr_arbiter.sv
// Round-robin owner of a shared 3:8 decoder. It drives the select lines {a,b,c} and the enable for the
// current grant holder, and inserts a one-cycle enable-low gap between any two grants.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no grant; enable low; waiting for any request
//   ST_GRANT | enable high; {a,b,c} = holder index; hold counter running
//   ST_GAP   | enable low for one cycle after a release; {a,b,c} keep the last index
module dec38_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       in,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       in_q, in_d;
  logic       timeout_q, timeout_d;

  logic [2:0] winner;
  logic       any_req;
  logic       hold_hit;
  logic       release_grant;

  // The scan starts one past the last winner. Offset 8 wraps back to ptr itself, so the previous
  // holder is considered last.
  always_comb begin
    winner  = ptr_q;
    any_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!any_req && req[ptr_q + 3'(k)]) begin
        winner  = ptr_q + 3'(k);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    hold_cnt_d    = hold_cnt_q;
    in_d          = 1'b0;
    timeout_d     = 1'b0;
    hold_hit      = (hold_cnt_q == HOLD_LAST);
    release_grant = done || !req[idx_q] || hold_hit;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (any_req) begin
          state_d    = ST_GRANT;
          idx_d      = winner;
          ptr_d      = winner;
          hold_cnt_d = 8'd0;
          in_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (release_grant) begin
          state_d   = ST_GAP;
          // A timeout is flagged only when the hold limit alone forced the release.
          timeout_d = hold_hit && !done && req[idx_q];
        end else begin
          in_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 3'd7;
      idx_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      in_q       <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      in_q       <= in_d;
      timeout_q  <= timeout_d;
    end
  end

  assign a       = idx_q[2];
  assign b       = idx_q[1];
  assign c       = idx_q[0];
  assign in      = in_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_dec38_rr_arbiter.sv
// Directed bench for dec38_rr_arbiter with HOLD_MAX=4. Each output sample is {in, a, b, c, timeout}
// and is taken 1 time unit after a rising clock edge.
module tb_dec38_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       a, b, c, in, timeout;

  int checks;
  int failures;

  dec38_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .a       (a),
    .b       (b),
    .c       (c),
    .in      (in),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    step();
    step();
    checks++;
    if ({in, a, b, c, timeout} !== 5'b0_000_0) begin
      failures++;
      $display("FAIL reset_hold: got %b want 00000", {in, a, b, c, timeout});
    end
    req   = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({in, a, b, c, timeout} !== 5'b0_000_0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got %b want 00000", i, {in, a, b, c, timeout});
      end
    end
  endtask

  task automatic test_single();
    req = 8'b0010_0000;
    step();
    checks++;
    if ({in, a, b, c, timeout} !== 5'b1_101_0) begin
      failures++;
      $display("FAIL single_grant: got %b want 11010", {in, a, b, c, timeout});
    end
    step();
    step();
    step();
    checks++;
    if ({in, a, b, c} !== 4'b1_101) begin
      failures++;
      $display("FAIL single_held: got %b want 1101", {in, a, b, c});
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({in, a, b, c, timeout} !== 5'b0_101_0) begin
      failures++;
      $display("FAIL single_release: got %b want 01010", {in, a, b, c, timeout});
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    do_reset();
    req  = 8'hFF;
    done = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      exp_idx = 3'(i);
      checks++;
      if ({in, a, b, c} !== {1'b1, exp_idx}) begin
        failures++;
        $display("FAIL rotation_grant[%0d]: got %b want 1%b", i, {in, a, b, c}, exp_idx);
      end
      step();
      checks++;
      if ({in, a, b, c, timeout} !== {1'b0, exp_idx, 1'b0}) begin
        failures++;
        $display("FAIL rotation_gap[%0d]: got %b want 0%b0", i, {in, a, b, c, timeout}, exp_idx);
      end
      if (i < 8) step();
    end
    req  = 8'h00;
    done = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h08;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({in, a, b, c, timeout} !== 5'b1_011_0) begin
        failures++;
        $display("FAIL timeout_hold[%0d]: got %b want 10110", k, {in, a, b, c, timeout});
      end
      step();
    end
    checks++;
    if ({in, timeout} !== 2'b01) begin
      failures++;
      $display("FAIL timeout_pulse: got in,timeout=%b want 01", {in, timeout});
    end
    step();
    checks++;
    if ({in, a, b, c, timeout} !== 5'b1_011_0) begin
      failures++;
      $display("FAIL timeout_regrant: got %b want 10110", {in, a, b, c, timeout});
    end
    req = 8'h00;
    step();
    checks++;
    if ({in, timeout} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_drop_release: got in,timeout=%b want 00", {in, timeout});
    end
    step();
  endtask

  task automatic test_drop();
    do_reset();
    req = 8'h44;
    step();
    checks++;
    if ({in, a, b, c} !== 4'b1_010) begin
      failures++;
      $display("FAIL drop_grant: got %b want 1010", {in, a, b, c});
    end
    step();
    req = 8'h40;
    step();
    checks++;
    if ({in, timeout} !== 2'b00) begin
      failures++;
      $display("FAIL drop_release: got in,timeout=%b want 00", {in, timeout});
    end
    step();
    checks++;
    if ({in, a, b, c, timeout} !== 5'b1_110_0) begin
      failures++;
      $display("FAIL drop_next: got %b want 11100", {in, a, b, c, timeout});
    end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_done_at_limit();
    do_reset();
    req = 8'h10;
    step();
    step();
    step();
    step();
    checks++;
    if ({in, a, b, c} !== 4'b1_100) begin
      failures++;
      $display("FAIL limit_held: got %b want 1100", {in, a, b, c});
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({in, timeout} !== 2'b00) begin
      failures++;
      $display("FAIL limit_done_no_timeout: got in,timeout=%b want 00", {in, timeout});
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h20;
    step();
    step();
    checks++;
    if ({in, a, b, c} !== 4'b1_101) begin
      failures++;
      $display("FAIL midrst_pre: got %b want 1101", {in, a, b, c});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in, a, b, c, timeout} !== 5'b0_000_0) begin
      failures++;
      $display("FAIL midrst_async: got %b want 00000", {in, a, b, c, timeout});
    end
    req = 8'h81;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({in, a, b, c} !== 4'b1_000) begin
      failures++;
      $display("FAIL midrst_first: got %b want 1000", {in, a, b, c});
    end
    done = 1'b1;
    step();
    step();
    checks++;
    if ({in, a, b, c} !== 4'b1_111) begin
      failures++;
      $display("FAIL midrst_second: got %b want 1111", {in, a, b, c});
    end
    done = 1'b0;
    req  = 8'h00;
    step();
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    done     = 1'b0;
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_drop();
    test_done_at_limit();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
